// File: rtl/dm_sba_bus_arbiter_if.sv
// Bus bundle for dm_sba_bus_arbiter: two upstream DM-protocol masters and one
// downstream slave port. The slave modport is the arbiter's view of the bundle.
interface dm_sba_bus_arbiter_if #(
  parameter int BusWidth = 32
);
  localparam int BeWidth = BusWidth / 8;

  logic [1:0]                       m_req_i;
  logic [1:0]                       m_we_i;
  logic [1:0][BusWidth-1:0]         m_addr_i;
  logic [1:0][BusWidth-1:0]         m_wdata_i;
  logic [1:0][BeWidth-1:0]          m_be_i;
  logic [1:0]                       m_gnt_o;
  logic [1:0]                       m_r_valid_o;
  logic [BusWidth-1:0]              m_r_rdata_o;

  logic                             s_req_o;
  logic                             s_we_o;
  logic [BusWidth-1:0]              s_addr_o;
  logic [BusWidth-1:0]              s_wdata_o;
  logic [BeWidth-1:0]               s_be_o;
  logic                             s_gnt_i;
  logic                             s_r_valid_i;
  logic [BusWidth-1:0]              s_r_rdata_i;

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, m_be_i,
    output m_gnt_o, m_r_valid_o, m_r_rdata_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o,
    input  s_gnt_i, s_r_valid_i, s_r_rdata_i
  );

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, m_be_i,
    input  m_gnt_o, m_r_valid_o, m_r_rdata_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o,
    output s_gnt_i, s_r_valid_i, s_r_rdata_i
  );
endinterface

// File: rtl/dm_sba_bus_arbiter.sv
// Core-data / debug-SBA arbiter onto one system-bus slave port, with an
// outstanding-ID FIFO for response routing. DM_SBA_ARB_FIXED_PRIO_EN: SBA wins ties.
//
// state     | meaning
// ST_OPEN   | no stalled request; selection follows the arbitration rule
// ST_LOCKED | a request was issued but not granted; selection held on lock_sel_q
module dm_sba_bus_arbiter #(
  parameter int BusWidth       = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  dm_sba_bus_arbiter_if.slave                  bus,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 err_o
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                    state_q;
  logic                      lock_sel_q;
  logic                      rr_q;
  logic                      err_q;
  logic [MaxOutstanding-1:0] id_q;
  logic [PtrW-1:0]           head_q;
  logic [PtrW-1:0]           tail_q;
  logic [CntW-1:0]           count_q;

  logic                      sel;
  logic                      room;
  logic                      s_req;
  logic                      push;
  logic                      pop;
  logic                      head_id;
  logic                      orphan_resp;
  logic                      lock_drop;
  logic [BusWidth-1:0]       addr_sel;
  logic [BusWidth-1:0]       wdata_sel;

  always_comb begin
    sel = rr_q;
    if (state_q == ST_LOCKED) begin
      sel = lock_sel_q;
    end else begin
      case (bus.m_req_i)
        2'b01:   sel = 1'b0;
        2'b10:   sel = 1'b1;
`ifdef DM_SBA_ARB_FIXED_PRIO_EN
        2'b11:   sel = 1'b1;
`else
        2'b11:   sel = rr_q;
`endif
        default: sel = rr_q;
      endcase
    end
  end

  // A response arriving this cycle frees a slot, so a full FIFO can still accept.
  assign room  = (count_q < MaxCnt) | bus.s_r_valid_i;
  assign s_req = bus.m_req_i[sel] & room;
  assign push  = s_req & bus.s_gnt_i;

  assign addr_sel  = bus.m_addr_i[sel];
  assign wdata_sel = bus.m_wdata_i[sel];

  assign bus.s_req_o   = s_req;
  assign bus.s_we_o    = bus.m_we_i[sel];
  assign bus.s_addr_o  = addr_sel;
  assign bus.s_wdata_o = wdata_sel;
  assign bus.s_be_o    = bus.m_be_i[sel];

  assign bus.m_gnt_o = push ? (sel ? 2'b10 : 2'b01) : 2'b00;

  assign head_id     = id_q[head_q];
  assign pop         = bus.s_r_valid_i & (count_q != '0);
  assign orphan_resp = bus.s_r_valid_i & (count_q == '0);

  assign bus.m_r_valid_o = pop ? (head_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_r_rdata_o = bus.s_r_rdata_i;

  // A locked master that withdraws before its grant breaks the handshake.
  assign lock_drop = (state_q == ST_LOCKED) & ~push & ~s_req & ~bus.m_req_i[lock_sel_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_OPEN;
      lock_sel_q <= 1'b0;
      rr_q       <= 1'b0;
      err_q      <= 1'b0;
      id_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      case (state_q)
        ST_OPEN: begin
          if (s_req & ~bus.s_gnt_i) begin
            state_q    <= ST_LOCKED;
            lock_sel_q <= sel;
          end
        end
        ST_LOCKED: begin
          if (push || lock_drop) begin
            state_q <= ST_OPEN;
          end
        end
        default: state_q <= ST_OPEN;
      endcase

      if (push) begin
        id_q[tail_q] <= sel;
        tail_q       <= (tail_q == LastPtr) ? '0 : tail_q + 1'b1;
        rr_q         <= ~sel;
      end

      if (pop) begin
        head_q <= (head_q == LastPtr) ? '0 : head_q + 1'b1;
      end

      count_q <= count_q + CntW'(push) - CntW'(pop);
      err_q   <= err_q | orphan_resp | lock_drop;
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_dm_sba_bus_arbiter.sv
// Self-checking bench for dm_sba_bus_arbiter: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_dm_sba_bus_arbiter;
  localparam int BW   = 32;
  localparam int MAXO = 2;
`ifdef DM_SBA_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] outstanding;
  logic       err;

  dm_sba_bus_arbiter_if #(.BusWidth(BW)) bus();

  dm_sba_bus_arbiter #(.BusWidth(BW), .MaxOutstanding(MAXO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .outstanding_o(outstanding),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: list of issuing ports in flight, round-robin bit, stall lock, sticky error.
  int   q[$];
  bit   m_rr, m_lk, m_lk_sel, m_err;

  always @(negedge clk) begin : compare
    int         cnt;
    bit         room, sel, e_sreq;
    logic [1:0] e_gnt, e_rv;
    if (rst) begin
      q.delete();
      m_rr = 0; m_lk = 0; m_lk_sel = 0; m_err = 0;
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err, 0);
    end else begin
      cnt  = q.size();
      room = (cnt < MAXO) || bus.s_r_valid_i;
      if (m_lk)                        sel = m_lk_sel;
      else if (bus.m_req_i == 2'b01)   sel = 0;
      else if (bus.m_req_i == 2'b10)   sel = 1;
      else if (bus.m_req_i == 2'b11)   sel = FIXED ? 1'b1 : m_rr;
      else                             sel = m_rr;
      e_sreq = bus.m_req_i[sel] && room;
      e_gnt  = (e_sreq && bus.s_gnt_i) ? (sel ? 2'b10 : 2'b01) : 2'b00;
      e_rv   = (bus.s_r_valid_i && cnt > 0) ? ((q[0] == 1) ? 2'b10 : 2'b01) : 2'b00;

      chk("s_req",       bus.s_req_o,     e_sreq);
      chk("s_we",        bus.s_we_o,      bus.m_we_i[sel]);
      chk("s_addr",      bus.s_addr_o,    bus.m_addr_i[sel]);
      chk("s_wdata",     bus.s_wdata_o,   bus.m_wdata_i[sel]);
      chk("s_be",        bus.s_be_o,      bus.m_be_i[sel]);
      chk("m_gnt",       bus.m_gnt_o,     e_gnt);
      chk("m_r_valid",   bus.m_r_valid_o, e_rv);
      chk("m_r_rdata",   bus.m_r_rdata_o, bus.s_r_rdata_i);
      chk("outstanding", outstanding,     cnt);
      chk("err",         err,             m_err);

      if (bus.s_r_valid_i) begin
        if (cnt > 0) void'(q.pop_front());
        else m_err = 1;
      end
      if (e_gnt != 2'b00) begin
        q.push_back(int'(sel));
        m_rr = !sel;
        m_lk = 0;
      end else if (e_sreq) begin
        m_lk = 1;
        m_lk_sel = sel;
      end else if (m_lk && !bus.m_req_i[m_lk_sel]) begin
        m_lk  = 0;
        m_err = 1;
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we, input bit sg,
                       input bit rv, input logic [31:0] rd);
    bus.m_req_i     = req;
    bus.m_we_i      = we;
    bus.s_gnt_i     = sg;
    bus.s_r_valid_i = rv;
    bus.s_r_rdata_i = rd;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    next();
    rst = 1'b0;
  endtask

  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [31:0] A1 = 32'h2000_0080;

  logic [1:0] exp_g [4];
  logic [1:0] exp_o [4];
  bit         pend  [2];

  initial begin
    drive(2'b00, 2'b00, 0, 0, 32'h0);
    bus.m_addr_i[0]  = A0;            bus.m_addr_i[1]  = A1;
    bus.m_wdata_i[0] = 32'h0A0A_0A0A; bus.m_wdata_i[1] = 32'h0B0B_0B0B;
    bus.m_be_i[0]    = 4'hF;          bus.m_be_i[1]    = 4'h3;
    repeat (2) next();
    rst = 1'b0;

    @(negedge clk);
    chk("reset_s_req",   bus.s_req_o, 0);
    chk("reset_gnt",     bus.m_gnt_o, 0);
    chk("reset_rvalid",  bus.m_r_valid_o, 0);
    chk("reset_count",   outstanding, 0);
    chk("reset_err",     err, 0);
    next();

    // Both requesting with grant every cycle; responses start after the FIFO fills.
    if (FIXED) exp_g = '{2'b10, 2'b10, 2'b10, 2'b10};
    else       exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_o = '{2'd0, 2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 1, (i >= 2), 32'h1111_0000 + i);
      @(negedge clk);
      chk("alt_gnt", bus.m_gnt_o, exp_g[i]);
      chk("alt_count", outstanding, exp_o[i]);
      if (i >= 2) chk("alt_rvalid", bus.m_r_valid_o, exp_g[i-2]);
      next();
    end
    for (int i = 0; i < 2; i++) begin drive(2'b00, 2'b00, 0, 1, 32'h0); next(); end

    // Capacity: two accepted reads, third blocked until a response frees a slot.
    for (int i = 0; i < 2; i++) begin drive(2'b01, 2'b00, 1, 0, 32'h0); next(); end
    drive(2'b01, 2'b00, 1, 0, 32'h0);
    @(negedge clk);
    chk("full_s_req", bus.s_req_o, 0);
    chk("full_gnt", bus.m_gnt_o, 0);
    chk("full_count", outstanding, 2);
    next();
    drive(2'b01, 2'b00, 1, 1, 32'hCAFE_0001);
    @(negedge clk);
    chk("full_pop_s_req", bus.s_req_o, 1);
    chk("full_pop_gnt", bus.m_gnt_o, 2'b01);
    chk("full_pop_rvalid", bus.m_r_valid_o, 2'b01);
    next();
    drive(2'b00, 2'b00, 0, 1, 32'h0);
    @(negedge clk);
    chk("full_pop_count", outstanding, 2);
    next();
    drive(2'b00, 2'b00, 0, 1, 32'h0); next();

    // Stall lock: p0 held through three refused cycles while p1 joins.
    drive(2'b01, 2'b00, 0, 0, 32'h0);
    @(negedge clk);
    chk("lock_addr0", bus.s_addr_o, A0);
    next();
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 2'b00, 0, 0, 32'h0);
      @(negedge clk);
      chk("lock_addr", bus.s_addr_o, A0);
      chk("lock_gnt", bus.m_gnt_o, 0);
      next();
    end
    drive(2'b11, 2'b00, 1, 0, 32'h0);
    @(negedge clk);
    chk("lock_release_gnt", bus.m_gnt_o, 2'b01);
    next();
    drive(2'b10, 2'b00, 1, 0, 32'h0);
    @(negedge clk);
    chk("lock_next_gnt", bus.m_gnt_o, 2'b10);
    chk("lock_next_addr", bus.s_addr_o, A1);
    next();
    for (int i = 0; i < 2; i++) begin drive(2'b00, 2'b00, 0, 1, 32'h0); next(); end

    // Interleaved p0 read and p1 write, responses routed in order.
    drive(2'b01, 2'b10, 1, 0, 32'h0);
    @(negedge clk); chk("il_gnt0", bus.m_gnt_o, 2'b01); chk("il_we0", bus.s_we_o, 0); next();
    drive(2'b10, 2'b10, 1, 0, 32'h0);
    @(negedge clk); chk("il_gnt1", bus.m_gnt_o, 2'b10); chk("il_we1", bus.s_we_o, 1); next();
    drive(2'b00, 2'b00, 0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("il_rvalid0", bus.m_r_valid_o, 2'b01);
    chk("il_rdata0", bus.m_r_rdata_o, 32'hDEAD_BEEF);
    next();
    drive(2'b00, 2'b00, 0, 1, 32'h1234_5678);
    @(negedge clk); chk("il_rvalid1", bus.m_r_valid_o, 2'b10); next();

    // Orphan response sets sticky error; reset clears it.
    drive(2'b00, 2'b00, 0, 1, 32'h5555_5555);
    @(negedge clk); chk("orphan_rvalid", bus.m_r_valid_o, 0); chk("orphan_err_before", err, 0); next();
    drive(2'b00, 2'b00, 0, 0, 32'h0);
    @(negedge clk); chk("orphan_err", err, 1); next();
    @(negedge clk); chk("orphan_err_sticky", err, 1); next();
    reset_pulse();
    @(negedge clk); chk("orphan_err_cleared", err, 0); next();

    // Locked master withdrawing its request.
    drive(2'b10, 2'b00, 0, 0, 32'h0); next();
    drive(2'b00, 2'b00, 0, 0, 32'h0);
    @(negedge clk); chk("drop_err_before", err, 0); next();
    @(negedge clk); chk("drop_err", err, 1); next();
    reset_pulse();

    // Reset with a read in flight: the late response is an orphan.
    drive(2'b01, 2'b00, 1, 0, 32'h0); next();
    drive(2'b00, 2'b00, 0, 0, 32'h0);
    reset_pulse();
    @(negedge clk); chk("midrst_count", outstanding, 0); next();
    drive(2'b00, 2'b00, 0, 1, 32'h7777_0000);
    @(negedge clk); chk("midrst_rvalid", bus.m_r_valid_o, 0); next();
    drive(2'b00, 2'b00, 0, 0, 32'h0);
    @(negedge clk); chk("midrst_err", err, 1); next();
    reset_pulse();

    // Random traffic: each master holds its request until granted.
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p]            = 1;
          bus.m_we_i[p]      = 1'($urandom_range(0, 1));
          bus.m_addr_i[p]    = $urandom;
          bus.m_wdata_i[p]   = $urandom;
          bus.m_be_i[p]      = 4'($urandom_range(0, 15));
        end
      end
      bus.m_req_i     = {pend[1], pend[0]};
      bus.s_gnt_i     = ($urandom_range(0, 2) != 0);
      bus.s_r_valid_i = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      bus.s_r_rdata_i = $urandom;
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (bus.m_gnt_o[p]) pend[p] = 0;
      next();
    end
    bus.m_req_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bus.s_gnt_i = 0;
      bus.s_r_valid_i = (q.size() > 0);
      next();
    end
    @(negedge clk);
    chk("final_count", outstanding, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
